// File: rtl/imem_pkg.sv
// Shared types and defaults for the instruction-memory responder.
package imem_pkg;

    typedef logic [31:0] word_t;
    typedef logic [31:0] addr_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam word_t NOP_WORD_DEF = 32'h00000013;

endpackage

// File: rtl/imem_array.sv
// Instruction storage: one synchronous write port, one registered read port.
// A read and a write to the same word on one edge return the old contents.
module imem_array
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH = 1024,
    parameter int unsigned AW    = 10
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  word_t         i_wdata,
    input  logic          i_re,
    input  logic [AW-1:0] i_raddr,
    output word_t         o_rdata
);

    word_t r_mem [DEPTH];
    word_t r_rdata;

    // Array write; contents survive reset so a loaded program is kept.
    always_ff @(posedge clk) begin
        if (i_we) begin
            r_mem[i_waddr] <= i_wdata;
        end
    end

    // Registered read; NBA ordering gives read-before-write on a collision.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata <= '0;
        end else if (i_re) begin
            r_rdata <= r_mem[i_raddr];
        end
    end

    assign o_rdata = r_rdata;

endmodule

// File: rtl/imem_responder.sv
// Fetch-side memory responder: accepts word-addressed requests, waits a fixed
// number of cycles, then returns the instruction with a one-cycle strobe.
module imem_responder
    import imem_pkg::*;
#(
    parameter int unsigned DEPTH       = 1024,
    parameter int unsigned WAIT_STATES = 1,
    parameter word_t       NOP_WORD    = NOP_WORD_DEF
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        i_req,
    input  logic [31:0] i_addr,
    output logic        o_ready,
    output logic [31:0] o_rdata,
    output logic        o_rvalid,
    output logic        o_fault,
    input  logic        i_load_en,
    input  logic [31:0] i_load_addr,
    input  logic [31:0] i_load_data
);

    localparam int unsigned AW         = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam addr_t       ADDR_LIMIT = addr_t'(DEPTH);
    localparam logic [3:0]  WS_LOAD    = 4'(WAIT_STATES);
    localparam bit          ZERO_WAIT  = (WAIT_STATES == 0);

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_cnt;
    logic [3:0] w_cnt_nxt;
    addr_t      r_addr_q;
    logic       r_rvalid;
    logic       r_fault;

    logic       w_accept;
    logic       w_resp_entry;
    addr_t      w_rd_addr;
    logic       w_rd_in_range;
    logic       w_load_we;
    word_t      w_arr_rdata;

    assign o_ready   = (r_state != WAIT) && !i_load_en;
    assign w_accept  = i_req && o_ready;

    // With zero wait states the read happens on the accepting edge, so the
    // incoming address is used before it lands in r_addr_q.
    assign w_rd_addr     = w_accept ? i_addr : r_addr_q;
    assign w_rd_in_range = (w_rd_addr < ADDR_LIMIT);
    assign w_load_we     = i_load_en && (i_load_addr < ADDR_LIMIT);

    // Next-state, wait counter and RESP-entry strobe.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_nxt    = r_cnt;
        w_resp_entry = 1'b0;
        case (r_state)
            IDLE, RESP: begin
                if (w_accept) begin
                    w_cnt_nxt = WS_LOAD;
                    if (ZERO_WAIT) begin
                        w_state_nxt  = RESP;
                        w_resp_entry = 1'b1;
                    end else begin
                        w_state_nxt = WAIT;
                    end
                end else begin
                    w_state_nxt = IDLE;
                end
            end
            WAIT: begin
                w_cnt_nxt = r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    w_state_nxt  = RESP;
                    w_resp_entry = 1'b1;
                end
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = '0;
            end
        endcase
    end

    // State, counter, latched address and response flags.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= IDLE;
            r_cnt    <= '0;
            r_addr_q <= '0;
            r_rvalid <= 1'b0;
            r_fault  <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_cnt    <= w_cnt_nxt;
            r_rvalid <= w_resp_entry;
            if (w_accept) begin
                r_addr_q <= i_addr;
            end
            if (w_resp_entry) begin
                r_fault <= !w_rd_in_range;
            end
        end
    end

    imem_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk),
        .rst     (rst),
        .i_we    (w_load_we),
        .i_waddr (i_load_addr[AW-1:0]),
        .i_wdata (i_load_data),
        .i_re    (w_resp_entry && w_rd_in_range),
        .i_raddr (w_rd_addr[AW-1:0]),
        .o_rdata (w_arr_rdata)
    );

    assign o_rvalid = r_rvalid;
    assign o_fault  = r_fault;
    assign o_rdata  = r_fault ? NOP_WORD : w_arr_rdata;

endmodule

// File: tb/tb_imem_responder.sv
// Bench for imem_responder: three instances (1, 0 and 3 wait states) share
// one stimulus stream and are compared against a cycle-count reference model.
module tb_imem_responder;

    localparam int unsigned DEPTH = 1024;
    localparam logic [31:0] NOP   = 32'h00000013;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        req = 1'b0;
    logic [31:0] addr = '0;
    logic        load_en = 1'b0;
    logic [31:0] load_addr = '0;
    logic [31:0] load_data = '0;

    logic [2:0]  rdy;
    logic [2:0]  rv;
    logic [2:0]  flt;
    logic [31:0] rd0, rd1, rd2;

    int n_assert = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    imem_responder #(.DEPTH(DEPTH), .WAIT_STATES(1)) u_dut0 (
        .clk(clk), .rst(rst), .i_req(req), .i_addr(addr), .o_ready(rdy[0]),
        .o_rdata(rd0), .o_rvalid(rv[0]), .o_fault(flt[0]), .i_load_en(load_en),
        .i_load_addr(load_addr), .i_load_data(load_data));

    imem_responder #(.DEPTH(DEPTH), .WAIT_STATES(0)) u_dut1 (
        .clk(clk), .rst(rst), .i_req(req), .i_addr(addr), .o_ready(rdy[1]),
        .o_rdata(rd1), .o_rvalid(rv[1]), .o_fault(flt[1]), .i_load_en(load_en),
        .i_load_addr(load_addr), .i_load_data(load_data));

    imem_responder #(.DEPTH(DEPTH), .WAIT_STATES(3)) u_dut2 (
        .clk(clk), .rst(rst), .i_req(req), .i_addr(addr), .o_ready(rdy[2]),
        .o_rdata(rd2), .o_rvalid(rv[2]), .o_fault(flt[2]), .i_load_en(load_en),
        .i_load_addr(load_addr), .i_load_data(load_data));

    // Reference model: a request taken in cycle t is answered in cycle
    // t+WS+1 and nothing new is taken before then; the word is whatever the
    // memory held before the loads of the edge that starts the answer cycle.
    int unsigned ws [3] = '{1, 0, 3};
    logic [31:0] m_mem [DEPTH];
    longint      cyc = 0;
    longint      m_free [3];
    longint      m_due  [3];
    logic [31:0] m_addr [3];
    bit          e_rv   [3];
    logic [31:0] e_rd   [3];
    bit          e_flt  [3];

    function automatic logic [31:0] rd_of(int k);
        return (k == 0) ? rd0 : (k == 1) ? rd1 : rd2;
    endfunction

    task automatic chk(string tag, int k, logic [31:0] obs, logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s dut%0d: observed %h expected %h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            m_free[k] = 0;
            m_due[k]  = -1;
            e_rv[k]   = 1'b0;
            e_rd[k]   = '0;
            e_flt[k]  = 1'b0;
        end
    endtask

    // One clock cycle: drive, check, advance model on the edge.
    task automatic step(bit r, logic [31:0] a, bit le, logic [31:0] la,
                        logic [31:0] ld, bit rs = 1'b0);
        bit acc;
        rst = rs; req = r; addr = a; load_en = le; load_addr = la; load_data = ld;
        if (rs) model_reset();
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("ready", k, {31'b0, rdy[k]}, {31'b0, (cyc >= m_free[k]) && !le});
            chk("rvalid", k, {31'b0, rv[k]}, {31'b0, e_rv[k]});
            if (e_rv[k]) begin
                chk("rdata", k, rd_of(k), e_rd[k]);
                chk("fault", k, {31'b0, flt[k]}, {31'b0, e_flt[k]});
            end
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (!rs) begin
                acc = (cyc >= m_free[k]) && r && !le;
                if (acc) begin
                    m_addr[k] = a;
                    m_due[k]  = cyc + 1 + ws[k];
                    m_free[k] = m_due[k];
                end
                if (m_due[k] == cyc + 1) begin
                    e_rv[k] = 1'b1;
                    if (m_addr[k] < DEPTH) begin
                        e_rd[k]  = m_mem[m_addr[k][9:0]];
                        e_flt[k] = 1'b0;
                    end else begin
                        e_rd[k]  = NOP;
                        e_flt[k] = 1'b1;
                    end
                end else begin
                    e_rv[k] = 1'b0;
                end
            end
        end
        if (le && la < DEPTH) m_mem[la[9:0]] = ld;
        cyc++;
        @(negedge clk);
    endtask

    task automatic idle(int n);
        for (int i = 0; i < n; i++) step(1'b0, '0, 1'b0, '0, '0);
    endtask

    initial begin
        logic [31:0] v;
        model_reset();
        @(negedge clk);
        step(1'b0, '0, 1'b0, '0, '0, 1'b1);
        step(1'b0, '0, 1'b0, '0, '0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            chk("rst_ready", k, {31'b0, rdy[k]}, 32'd1);
            chk("rst_rvalid", k, {31'b0, rv[k]}, 32'd0);
            chk("rst_rdata", k, rd_of(k), 32'd0);
            chk("rst_fault", k, {31'b0, flt[k]}, 32'd0);
        end
        idle(1);

        // Program the whole array so every fetch has a known answer.
        for (int i = 0; i < DEPTH; i++) begin
            if (i < 4)          v = 32'd10 + 32'(i);
            else if (i == 5)    v = 32'hDEADBEEF;
            else if (i == 7)    v = 32'd1;
            else if (i == 9)    v = 32'h12345678;
            else if (i == 976)  v = 32'hA5A50976;
            else                v = $urandom;
            step(1'b0, '0, 1'b1, 32'(i), v);
        end

        // Single fetch with one wait state.
        step(1'b1, 32'd5, 1'b0, '0, '0);
        chk("t1_wait_ready", 0, {31'b0, rdy[0]}, 32'd0);
        chk("t1_ws0_rdata", 1, rd1, 32'hDEADBEEF);
        step(1'b0, '0, 1'b0, '0, '0);
        chk("t1_rvalid", 0, {31'b0, rv[0]}, 32'd1);
        chk("t1_rdata", 0, rd0, 32'hDEADBEEF);
        chk("t1_fault", 0, {31'b0, flt[0]}, 32'd0);
        idle(6);

        // Back-to-back fetches.
        for (int i = 0; i < 4; i++) begin
            step(1'b1, 32'(i), 1'b0, '0, '0);
            chk("t2_rvalid", 1, {31'b0, rv[1]}, 32'd1);
            chk("t2_rdata", 1, rd1, 32'd10 + 32'(i));
        end
        idle(6);

        // Out-of-range fetch and dropped out-of-range load.
        step(1'b1, 32'd1024, 1'b0, '0, '0);
        chk("t3_rdata", 1, rd1, NOP);
        chk("t3_fault", 1, {31'b0, flt[1]}, 32'd1);
        idle(6);
        step(1'b0, '0, 1'b1, 32'd2000, 32'h00000BAD);
        step(1'b1, 32'd976, 1'b0, '0, '0);
        chk("t3_noalias", 1, rd1, 32'hA5A50976);
        chk("t3_noalias_fault", 1, {31'b0, flt[1]}, 32'd0);
        idle(6);
        step(1'b1, 32'h80000003, 1'b0, '0, '0);
        chk("t3_hi_fault", 1, {31'b0, flt[1]}, 32'd1);
        idle(6);

        // Load during WAIT is seen; load on the RESP-entry edge is not.
        step(1'b1, 32'd7, 1'b0, '0, '0);
        step(1'b0, '0, 1'b1, 32'd7, 32'd2);
        idle(2);
        chk("t4_wait_load_rv", 2, {31'b0, rv[2]}, 32'd1);
        chk("t4_wait_load", 2, rd2, 32'd2);
        idle(6);
        step(1'b0, '0, 1'b1, 32'd7, 32'd1);
        step(1'b1, 32'd7, 1'b0, '0, '0);
        idle(2);
        step(1'b0, '0, 1'b1, 32'd7, 32'd9);
        chk("t4_same_edge_rv", 2, {31'b0, rv[2]}, 32'd1);
        chk("t4_same_edge", 2, rd2, 32'd1);
        idle(6);

        // Loader blocks requests.
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 32'd9, 1'b1, 32'd20, 32'h2020);
            for (int k = 0; k < 3; k++) chk("t5_ready", k, {31'b0, rdy[k]}, 32'd0);
        end
        idle(1);
        for (int k = 0; k < 3; k++) chk("t5_no_rvalid", k, {31'b0, rv[k]}, 32'd0);
        idle(3);

        // Reset while waiting discards the response but keeps memory.
        step(1'b1, 32'd9, 1'b0, '0, '0);
        step(1'b0, '0, 1'b0, '0, '0);
        step(1'b0, '0, 1'b0, '0, '0, 1'b1);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b0, '0, '0);
            chk("t6_no_rvalid", 2, {31'b0, rv[2]}, 32'd0);
        end
        step(1'b1, 32'd9, 1'b0, '0, '0);
        chk("t6_kept_rv", 1, {31'b0, rv[1]}, 32'd1);
        chk("t6_kept", 1, rd1, 32'h12345678);
        idle(6);

        // Random traffic against the model.
        for (int i = 0; i < 600; i++) begin
            bit          r, le, rs;
            logic [31:0] a, la;
            r  = ($urandom_range(99) < 60);
            le = ($urandom_range(99) < 20);
            rs = ($urandom_range(199) == 0);
            case ($urandom_range(9))
                0:       a = 32'd1000 + $urandom_range(60);
                1:       a = $urandom | 32'h80000000;
                default: a = $urandom_range(15);
            endcase
            la = ($urandom_range(9) == 0) ? 32'd1024 + $urandom_range(40)
                                         : $urandom_range(15);
            if (rs) le = 1'b0;
            step(r, a, le, la, $urandom, rs);
        end
        idle(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/imem_responder.md
# imem_responder

Instruction-memory responder for the CPU fetch path: it is the memory end of the fetch-address / instruction-data interface. It accepts word-addressed fetch requests, models a fixed number of wait states, and returns the addressed 32-bit instruction with a one-cycle valid pulse. A loader write port lets the boot logic or testbench program the array while the core runs.

## Interface

- `DEPTH`, 1024: number of 32-bit instruction words.
- `WAIT_STATES`, 1: extra cycles between request acceptance and response. The range is 0..15.
- `NOP_WORD`, 32'h00000013: word returned on an out-of-range fetch.
- `clk` input, 1: clock.
- `rst` input, 1: reset, asynchronous, active-high.
- `req` input, 1: fetch request, qualified by `ready`.
- `addr` input, 32: word address. It increments by 1 per instruction.
- `ready` output, 1: a request is accepted this cycle when `req && ready`.
- `rdata` output, 32: instruction word, valid only while `rvalid` is high.
- `rvalid` output, 1: one-cycle response strobe.
- `fault` output, 1: out-of-range flag. It is qualified by `rvalid`.
- `load_en` input, 1: loader write strobe.
- `load_addr` input, 32: loader word address.
- `load_data` input, 32: loader write data.

## Operation

- The FSM has three states: IDLE, WAIT, RESP.
- `ready` = (state != WAIT) && !`load_en`.
  - Requests are accepted in IDLE and in RESP, which allows back-to-back fetches.
  - No request is accepted while `load_en` is high.
- Accepting a request latches `addr` into `addr_q` and loads the wait counter with `WAIT_STATES`.
  - If `WAIT_STATES`==0, the FSM goes straight to RESP.
  - Otherwise it goes to WAIT.
- In WAIT, the counter decrements each cycle. At 1 the FSM moves to RESP on the next edge.
- On entry to RESP, `rdata`, `rvalid` and `fault` are registered:
  - If `addr_q` < `DEPTH`: `rdata` = mem[`addr_q`], `fault`=0.
  - Otherwise: `rdata` = `NOP_WORD`, `fault`=1.
  - `rvalid`=1 for exactly the RESP cycle.
- Leaving RESP: to WAIT or RESP if a new request is accepted, otherwise to IDLE. `rvalid` clears unless a new response is produced.
- Loader writes:
  - When `load_en`=1 and `load_addr` < `DEPTH`, mem[`load_addr`] is written at the clock edge, in any state.
  - An out-of-range `load_addr` is silently dropped.
- If a load and a response read hit the same word on the same edge, the read returns the old data (read-before-write).
- A load to `addr_q` during WAIT is visible in the response, because the array is read on the RESP-entry edge.
- Reset, including mid-operation:
  - State goes to IDLE and the counter to 0.
  - `rvalid`=0, `fault`=0, `rdata`=0.
  - A pending response is discarded.
  - Memory contents are NOT cleared.
- Reset values: `ready`=1 (while `load_en`=0), `rvalid`=0, `rdata`=0, `fault`=0.

## Timing

- Latency: a request accepted at edge E0 produces `rvalid` high in the cycle after edge E(WAIT_STATES+1).
  - With the default `WAIT_STATES`=1, that is 2 edges after acceptance.
  - With `WAIT_STATES`=0, it is 1 edge after acceptance.
- Throughput:
  - One response per `WAIT_STATES`+1 cycles under continuous `req`.
  - Full rate, one per cycle, when `WAIT_STATES`=0.
- `ready` is combinational from state and `load_en`. All other outputs are registered.
- Address comparison uses the full 32-bit `addr_q`. Values at or above `DEPTH` fault; there is no wrap-around.

## Structure

- Shared package `imem_pkg`: state enum (IDLE/WAIT/RESP), `NOP_WORD` default, 32-bit word and address typedefs.
- Sub-module `imem_array`: `DEPTH`×32 storage with one synchronous write port and one synchronous read port, read-before-write. The FSM, counter and range check live in the top.

## Test plan

- Reset, then load mem[5]=32'hDEADBEEF, then `req` with `addr`=5, `WAIT_STATES`=1 -> `rvalid` exactly 2 edges later with `rdata`=32'hDEADBEEF and `fault`=0; `ready`=0 during WAIT.
- Continuous `req` at addrs 0,1,2,3 with `WAIT_STATES`=0, preloaded values 10..13 -> `rvalid` high 4 consecutive cycles with `rdata` 10,11,12,13.
- `req` `addr`=1024 (=`DEPTH`) -> `rvalid` with `rdata`=32'h00000013 and `fault`=1; a load to `load_addr`=2000 leaves the array unchanged.
- `req` `addr`=7 (mem[7]=1), then `load_en` writing mem[7]=2 during WAIT -> response `rdata`=2; a same-edge load at RESP entry -> `rdata`=1.
- `load_en`=1 with `req`=1 -> `ready`=0, no request accepted, no `rvalid`.
- `rst` asserted during WAIT -> `rvalid` never rises, state is IDLE; after release, a fetch of a previously loaded word returns the preserved data.
